// File: rtl/uart_pkg.sv
// Shared UART configuration: default rates and the rounded RX divider.
package uart_pkg;

    localparam int CLK_FREQ_DEF   = 50_000_000;
    localparam int BAUD_DEF       = 9600;
    localparam int OVERSAMPLE_DEF = 16;

    // Round-to-nearest of clk / (baud * os); the residual rate error is accepted.
    function automatic int calc_div(input int clk, input int baud, input int os);
        int den;
        den = baud * os;
        return (clk + den / 2) / den;
    endfunction

endpackage

// File: rtl/strobe_div.sv
// Enable-gated divide-by-N counter with a registered one-cycle strobe.
module strobe_div #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o,
    output logic strobe_o
);

    localparam int           W    = $clog2(N) + 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         strobe_q, strobe_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tick_o   = en_i && (cnt_q == LAST);
        cnt_d    = cnt_q;
        strobe_d = tick_o;
        if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud tick generator: RX strobe at BAUD*OVERSAMPLE, TX strobe at BAUD.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEF,
    parameter int BAUD       = BAUD_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic Clock,
    input  logic Reset,
    output logic RX_Clock,
    output logic TX_Clock
);

    localparam int RX_DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

    generate
        if (RX_DIV < 1 || OVERSAMPLE < 2) begin : g_bad_cfg
            $error("uart_baud_gen: RX_DIV=%0d OVERSAMPLE=%0d not supported", RX_DIV, OVERSAMPLE);
        end
    endgenerate

    logic rx_tick;
    logic rx_strobe;
    logic os_tick_unused;
    logic os_strobe;

    strobe_div #(.N(RX_DIV)) u_rx_div (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .en_i     (1'b1),
        .tick_o   (rx_tick),
        .strobe_o (rx_strobe)
    );

    // The oversample counter advances on the same cycle rx_cnt wraps, so its
    // strobe registers on the same edge as the matching RX strobe.
    strobe_div #(.N(OVERSAMPLE)) u_os_div (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .en_i     (rx_tick),
        .tick_o   (os_tick_unused),
        .strobe_o (os_strobe)
    );

    assign RX_Clock = rx_strobe;
    assign TX_Clock = os_strobe & rx_strobe;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen at RX_DIV=10, 27 and 1.
module tb_uart_baud_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rx_a, tx_a, rx_b, tx_b, rx_c, tx_c;

    uart_baud_gen #(.CLK_FREQ(1600), .BAUD(10), .OVERSAMPLE(16)) u_dut_a (
        .Clock(clk), .Reset(rst), .RX_Clock(rx_a), .TX_Clock(tx_a));
    uart_baud_gen #(.CLK_FREQ(50_000_000), .BAUD(115200), .OVERSAMPLE(16)) u_dut_b (
        .Clock(clk), .Reset(rst), .RX_Clock(rx_b), .TX_Clock(tx_b));
    uart_baud_gen #(.CLK_FREQ(160), .BAUD(10), .OVERSAMPLE(16)) u_dut_c (
        .Clock(clk), .Reset(rst), .RX_Clock(rx_c), .TX_Clock(tx_c));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int mism_a, mism_b, mism_c;
    int rx_cnt_a, tx_cnt_a, tx_cnt_c, long_a, long_b, align_err;
    int last_rx_b, last_tx_b, per_rx_b, per_tx_b;
    int first_rx, first_tx, rst_strobes;
    logic prev_rx_a, prev_rx_b;

    initial begin
        rst = 1'b1;
        // 1. Reset held 5 cycles: all strobes low.
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_quiet", {26'd0, rx_a, tx_a, rx_b, tx_b, rx_c, tx_c}, 32'd0);
        end
        rst = 1'b0;

        // 2/3/5/6. Free run of 2000 cycles on all three configurations.
        mism_a = 0; mism_b = 0; mism_c = 0;
        rx_cnt_a = 0; tx_cnt_a = 0; tx_cnt_c = 0; long_a = 0; long_b = 0; align_err = 0;
        last_rx_b = -1; last_tx_b = -1; per_rx_b = 0; per_tx_b = 0;
        prev_rx_a = 1'b0; prev_rx_b = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            step();
            if (c == 9)  check("first_rx_c9",  rx_a, 1'b0);
            if (c == 10) check("first_rx_c10", rx_a, 1'b1);
            if (c == 11) check("first_rx_c11", rx_a, 1'b0);
            if (rx_a !== (c % 10 == 0) || tx_a !== (c % 160 == 0)) mism_a++;
            if (rx_b !== (c % 27 == 0) || tx_b !== (c % 432 == 0)) mism_b++;
            if (rx_c !== 1'b1 || tx_c !== (c % 16 == 0)) mism_c++;
            if (rx_a === 1'b1) rx_cnt_a++;
            if (tx_a === 1'b1) begin
                tx_cnt_a++;
                if (rx_a !== 1'b1 || rx_cnt_a % 16 != 0) align_err++;
            end
            if (tx_c === 1'b1) tx_cnt_c++;
            if (rx_a === 1'b1 && prev_rx_a === 1'b1) long_a++;
            if (rx_b === 1'b1 && prev_rx_b === 1'b1) long_b++;
            prev_rx_a = rx_a;
            prev_rx_b = rx_b;
            if (rx_b === 1'b1) begin
                if (last_rx_b >= 0 && per_rx_b == 0) per_rx_b = c - last_rx_b;
                last_rx_b = c;
            end
            if (tx_b === 1'b1) begin
                if (last_tx_b >= 0 && per_tx_b == 0) per_tx_b = c - last_tx_b;
                last_tx_b = c;
            end
        end
        check("a_pattern",   mism_a,    0);
        check("a_rx_pulses", rx_cnt_a,  200);
        check("a_tx_pulses", tx_cnt_a,  12);
        check("a_rx_width",  long_a,    0);
        check("a_alignment", align_err, 0);
        check("b_pattern",   mism_b,    0);
        check("b_rx_width",  long_b,    0);
        check("b_rx_period", per_rx_b,  27);
        check("b_tx_period", per_tx_b,  432);
        check("c_pattern",   mism_c,    0);
        check("c_tx_pulses", tx_cnt_c,  125);

        // 4. Fresh start, then a one-cycle reset at cycle 85.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        mism_a = 0;
        for (int c = 1; c <= 85; c++) begin
            step();
            if (rx_a !== (c % 10 == 0) || tx_a !== (c % 160 == 0)) mism_a++;
        end
        check("pre_reset_pattern", mism_a, 0);
        rst = 1'b1;
        step();
        rst_strobes = {29'd0, rx_a, tx_a, rx_b} + {31'd0, tx_b};
        check("mid_reset_quiet", rst_strobes, 0);
        rst = 1'b0;
        mism_a = 0; first_rx = -1; first_tx = -1;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (rx_a !== (c % 10 == 0) || tx_a !== (c % 160 == 0)) mism_a++;
            if (rx_a === 1'b1 && first_rx < 0) first_rx = c;
            if (tx_a === 1'b1 && first_tx < 0) first_tx = c;
        end
        check("post_reset_pattern",  mism_a,   0);
        check("post_reset_first_rx", first_rx, 10);
        check("post_reset_first_tx", first_tx, 160);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
